// File: rtl/fp_multiplier_stage2.sv
// FP multiplier stage 2: two-deep pipelined unsigned significand multiply.
// Partial products are registered first, then summed into the product.
module fp_multiplier_stage2 #(
    parameter int OPERAND_WIDTH = 32,
    parameter int HALF_WIDTH    = OPERAND_WIDTH / 2,
    parameter int PRODUCT_WIDTH = 2 * OPERAND_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     mul1_valid,
    input  logic [OPERAND_WIDTH-1:0] mul1_muliplicand,
    input  logic [OPERAND_WIDTH-1:0] mul1_multiplier,
    input  logic [7:0]               mul1_exponent,
    input  logic                     mul1_sign,
    input  logic                     mul1_overflow,
    input  logic                     mul1_underflow,
    output logic                     mul2_valid,
    output logic [PRODUCT_WIDTH-1:0] mul2_product,
    output logic [7:0]               mul2_exponent,
    output logic                     mul2_sign,
    output logic                     mul2_overflow,
    output logic                     mul2_underflow
);

    localparam int PP_WIDTH  = 2 * HALF_WIDTH;
    localparam int MID_WIDTH = PP_WIDTH + 1;

    logic [HALF_WIDTH-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [PP_WIDTH-1:0]   ll_c, lh_c, hl_c, hh_c;

    logic [PP_WIDTH-1:0]   pp_ll, pp_lh, pp_hl, pp_hh;
    logic                  valid_p;
    logic [7:0]            exponent_p;
    logic                  sign_p;
    logic                  overflow_p;
    logic                  underflow_p;

    logic [MID_WIDTH-1:0]     mid_sum;
    logic [PRODUCT_WIDTH-1:0] product_c;

    assign a_lo = mul1_muliplicand[HALF_WIDTH-1:0];
    assign a_hi = mul1_muliplicand[OPERAND_WIDTH-1:HALF_WIDTH];
    assign b_lo = mul1_multiplier[HALF_WIDTH-1:0];
    assign b_hi = mul1_multiplier[OPERAND_WIDTH-1:HALF_WIDTH];

    assign ll_c = PP_WIDTH'(a_lo) * PP_WIDTH'(b_lo);
    assign lh_c = PP_WIDTH'(a_lo) * PP_WIDTH'(b_hi);
    assign hl_c = PP_WIDTH'(a_hi) * PP_WIDTH'(b_lo);
    assign hh_c = PP_WIDTH'(a_hi) * PP_WIDTH'(b_hi);

    // Middle sum keeps one extra bit so the cross-term carry survives
    assign mid_sum   = {1'b0, pp_lh} + {1'b0, pp_hl};
    assign product_c = PRODUCT_WIDTH'(pp_ll)
                     + (PRODUCT_WIDTH'(mid_sum) << HALF_WIDTH)
                     + (PRODUCT_WIDTH'(pp_hh) << OPERAND_WIDTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pp_ll       <= '0;
            pp_lh       <= '0;
            pp_hl       <= '0;
            pp_hh       <= '0;
            valid_p     <= 1'b0;
            exponent_p  <= '0;
            sign_p      <= 1'b0;
            overflow_p  <= 1'b0;
            underflow_p <= 1'b0;
        end else if (!stall) begin
            pp_ll       <= ll_c;
            pp_lh       <= lh_c;
            pp_hl       <= hl_c;
            pp_hh       <= hh_c;
            valid_p     <= mul1_valid;
            exponent_p  <= mul1_exponent;
            sign_p      <= mul1_sign;
            overflow_p  <= mul1_overflow;
            underflow_p <= mul1_underflow;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul2_valid     <= 1'b0;
            mul2_product   <= '0;
            mul2_exponent  <= '0;
            mul2_sign      <= 1'b0;
            mul2_overflow  <= 1'b0;
            mul2_underflow <= 1'b0;
        end else if (!stall) begin
            mul2_valid     <= valid_p;
            mul2_product   <= product_c;
            mul2_exponent  <= exponent_p;
            mul2_sign      <= sign_p;
            mul2_overflow  <= overflow_p;
            mul2_underflow <= underflow_p;
        end
    end

endmodule

// File: tb/tb_fp_multiplier_stage2.sv
// Directed bench for fp_multiplier_stage2 with hand-computed products.
// Covers reset, arithmetic corners, bubbles, stall and mid-flight reset.
module tb_fp_multiplier_stage2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        mul1_valid;
    logic [31:0] mul1_muliplicand;
    logic [31:0] mul1_multiplier;
    logic [7:0]  mul1_exponent;
    logic        mul1_sign;
    logic        mul1_overflow;
    logic        mul1_underflow;
    logic        mul2_valid;
    logic [63:0] mul2_product;
    logic [7:0]  mul2_exponent;
    logic        mul2_sign;
    logic        mul2_overflow;
    logic        mul2_underflow;

    int checks = 0;
    int errors = 0;

    fp_multiplier_stage2 dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .mul1_valid       (mul1_valid),
        .mul1_muliplicand (mul1_muliplicand),
        .mul1_multiplier  (mul1_multiplier),
        .mul1_exponent    (mul1_exponent),
        .mul1_sign        (mul1_sign),
        .mul1_overflow    (mul1_overflow),
        .mul1_underflow   (mul1_underflow),
        .mul2_valid       (mul2_valid),
        .mul2_product     (mul2_product),
        .mul2_exponent    (mul2_exponent),
        .mul2_sign        (mul2_sign),
        .mul2_overflow    (mul2_overflow),
        .mul2_underflow   (mul2_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [7:0] e,
                         input logic s, input logic ov, input logic un);
        mul1_valid       = v;
        mul1_muliplicand = a;
        mul1_multiplier  = b;
        mul1_exponent    = e;
        mul1_sign        = s;
        mul1_overflow    = ov;
        mul1_underflow   = un;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_out(input string tag, input logic v,
                             input logic [63:0] p, input logic [7:0] e,
                             input logic s, input logic ov, input logic un);
        check({tag, ".valid"}, 64'(mul2_valid), 64'(v));
        check({tag, ".product"}, mul2_product, p);
        check({tag, ".exp"}, 64'(mul2_exponent), 64'(e));
        check({tag, ".sign"}, 64'(mul2_sign), 64'(s));
        check({tag, ".ovf"}, 64'(mul2_overflow), 64'(ov));
        check({tag, ".unf"}, 64'(mul2_underflow), 64'(un));
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        idle();
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        step();
        step();
        check_out("reset", 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        idle();

        // 1.0 * 1.0
        drive(1'b1, 32'h00800000, 32'h00800000, 8'h7F, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        check_out("one", 1'b1, 64'h0000400000000000, 8'h7F, 1'b0, 1'b0, 1'b0);

        // Max operands exercise the middle-sum carry
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h80, 1'b0, 1'b1, 1'b0);
        step();
        idle();
        step();
        check_out("max", 1'b1, 64'hFFFFFFFE00000001, 8'h80, 1'b0, 1'b1, 1'b0);

        // Integer-to-float path
        drive(1'b1, 32'h00800000, 32'h00000005, 8'h96, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        step();
        check_out("int", 1'b1, 64'h0000000002800000, 8'h96, 1'b1, 1'b0, 1'b0);

        // Zero operand, flags still pass through
        drive(1'b1, 32'h00000000, 32'hDEADBEEF, 8'hAA, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        step();
        check_out("zero", 1'b1, 64'h0, 8'hAA, 1'b1, 1'b1, 1'b1);

        // Back-to-back with a bubble
        drive(1'b1, 32'd3, 32'd7, 8'h11, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        check_out("b2b.x", 1'b1, 64'd21, 8'h11, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00010000, 32'h00010000, 8'h22, 1'b1, 1'b0, 1'b0);
        step();
        check("b2b.bubble", 64'(mul2_valid), 64'd0);
        idle();
        step();
        check_out("b2b.y", 1'b1, 64'h0000000100000000, 8'h22, 1'b1, 1'b0, 1'b0);

        // Stall with two ops in flight
        drive(1'b1, 32'h12345678, 32'h00000002, 8'h33, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hFFFF0000, 32'h00010000, 8'h44, 1'b1, 1'b0, 1'b1);
        step();
        check_out("stall.a", 1'b1, 64'h000000002468ACF0, 8'h33, 1'b0, 1'b1, 1'b0);
        stall = 1'b1;
        drive(1'b1, 32'h00000009, 32'h00000009, 8'h55, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall.hold", 1'b1, 64'h000000002468ACF0, 8'h33, 1'b0, 1'b1, 1'b0);
        end
        stall = 1'b0;
        idle();
        step();
        check_out("stall.b", 1'b1, 64'h0000FFFF00000000, 8'h44, 1'b1, 1'b0, 1'b1);
        step();
        check("stall.nodup", 64'(mul2_valid), 64'd0);

        // Reset with two ops in flight
        drive(1'b1, 32'h00000100, 32'h00000100, 8'h66, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h00000200, 32'h00000200, 8'h77, 1'b0, 1'b0, 1'b1);
        step();
        check("rst.pre", mul2_product, 64'h0000000000010000);
        #2;
        reset = 1'b1;
        #1;
        check_out("rst.async", 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        stall = 1'b1;
        idle();
        step();
        check_out("rst.stall", 1'b0, 64'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        stall = 1'b0;
        step();
        check("rst.after1", 64'(mul2_valid), 64'd0);
        step();
        check("rst.after2", 64'(mul2_valid), 64'd0);
        drive(1'b1, 32'h00010001, 32'h00010001, 8'h88, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        check("rst.lat1", 64'(mul2_valid), 64'd0);
        step();
        check_out("rst.new", 1'b1, 64'h0000000100020001, 8'h88, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
